// File: rtl/param_cc_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : PARAMETER (package) / param_cc_transmitter_if (interface)
// Purpose  : Live synth parameter struct and the MIDI TX byte handshake bus.
// Revision : 1.0 - initial release
// ============================================================================

package PARAMETER;

    localparam int W_VOLUME          = 7;
    localparam int W_UNISON_DETUNE   = 7;
    localparam int W_ATTACK_TIME     = 8;
    localparam int W_DECAY_TIME      = 8;
    localparam int W_SUSTAIN_LEVEL   = 7;
    localparam int W_RELEASE_TIME    = 8;
    localparam int W_TEMPO           = 8;
    localparam int W_WAVE            = 2;
    localparam int W_DUTY_CYCLE      = 7;
    localparam int W_DISPATCHER_MODE = 2;
    localparam int W_ARP_MODE        = 3;
    localparam int W_ARP_RATE        = 4;
    localparam int W_ARP_RHYTHM      = 4;

    typedef struct packed {
        logic [W_VOLUME-1:0]          volume;
        logic [W_UNISON_DETUNE-1:0]   unison_detune;
        logic [W_ATTACK_TIME-1:0]     attack_time;
        logic [W_DECAY_TIME-1:0]      decay_time;
        logic [W_SUSTAIN_LEVEL-1:0]   sustain_level;
        logic [W_RELEASE_TIME-1:0]    release_time;
        logic [W_TEMPO-1:0]           tempo;
        logic [W_WAVE-1:0]            wave;
        logic [W_DUTY_CYCLE-1:0]      duty_cycle;
        logic [W_DISPATCHER_MODE-1:0] dispatcher_mode;
        logic [W_ARP_MODE-1:0]        arp_mode;
        logic [W_ARP_RATE-1:0]        arp_rate;
        logic [W_ARP_RHYTHM-1:0]      arp_rhythm;
    } parameter_t;

endpackage

interface param_cc_transmitter_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/param_cc_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : param_cc_transmitter
// Purpose  : Mirrors the live parameter struct out as 3-byte MIDI CC messages,
//            sending only fields that differ from the last value sent.
// Revision : 1.0 - initial release
// ============================================================================

module param_cc_transmitter #(
    parameter int CHANNEL = 0,
    parameter int CC_BASE = 20
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire PARAMETER::parameter_t params,
    input  wire logic                  dump_req,
    param_cc_transmitter_if.master     tx,
    output logic                       busy,
    output logic                       dump_done
);

    localparam int c_num_fields = 13;
    localparam int c_raw_w      = 8;

    localparam int c_width [c_num_fields] = '{
        PARAMETER::W_VOLUME,       PARAMETER::W_UNISON_DETUNE, PARAMETER::W_ATTACK_TIME,
        PARAMETER::W_DECAY_TIME,   PARAMETER::W_SUSTAIN_LEVEL, PARAMETER::W_RELEASE_TIME,
        PARAMETER::W_TEMPO,        PARAMETER::W_WAVE,          PARAMETER::W_DUTY_CYCLE,
        PARAMETER::W_DISPATCHER_MODE, PARAMETER::W_ARP_MODE,   PARAMETER::W_ARP_RATE,
        PARAMETER::W_ARP_RHYTHM
    };

    localparam logic [7:0] c_status  = {4'hB, 4'(CHANNEL)};
    localparam logic [7:0] c_cc_base = 8'(CC_BASE);
    localparam logic [3:0] c_last    = 4'(c_num_fields - 1);

    typedef enum logic [1:0] {
        S_SCAN   = 2'd0,
        S_STATUS = 2'd1,
        S_CTRL   = 2'd2,
        S_VALUE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [c_raw_w-1:0]      w_raw    [c_num_fields];
    logic [6:0]              w_cc     [c_num_fields];
    logic [c_num_fields-1:0] w_dirty;
    logic [c_raw_w-1:0]      r_shadow [c_num_fields];
    logic [c_num_fields-1:0] r_force;
    logic [3:0]              r_ptr;
    logic [3:0]              r_idx;
    logic [6:0]              r_val;
    logic [c_raw_w-1:0]      r_raw;
    logic                    r_dump_pending;
    logic                    r_live;
    logic                    w_capture;
    logic                    w_commit;

    function automatic logic [3:0] f_next(input logic [3:0] i);
        return (i == c_last) ? 4'd0 : i + 4'd1;
    endfunction

    // Every field is held zero-extended to a common width so the shadow compare
    // covers the full field.
    always_comb begin
        w_raw[0]  = c_raw_w'(params.volume);
        w_raw[1]  = c_raw_w'(params.unison_detune);
        w_raw[2]  = c_raw_w'(params.attack_time);
        w_raw[3]  = c_raw_w'(params.decay_time);
        w_raw[4]  = c_raw_w'(params.sustain_level);
        w_raw[5]  = c_raw_w'(params.release_time);
        w_raw[6]  = c_raw_w'(params.tempo);
        w_raw[7]  = c_raw_w'(params.wave);
        w_raw[8]  = c_raw_w'(params.duty_cycle);
        w_raw[9]  = c_raw_w'(params.dispatcher_mode);
        w_raw[10] = c_raw_w'(params.arp_mode);
        w_raw[11] = c_raw_w'(params.arp_rate);
        w_raw[12] = c_raw_w'(params.arp_rhythm);
    end

    for (genvar gi = 0; gi < c_num_fields; gi++) begin : g_field
        if (c_width[gi] > 7) begin : g_sat
            assign w_cc[gi] = (w_raw[gi] > c_raw_w'(127)) ? 7'h7F : w_raw[gi][6:0];
        end else begin : g_pass
            assign w_cc[gi] = w_raw[gi][6:0];
        end
        assign w_dirty[gi] = (w_raw[gi] != r_shadow[gi]) | r_force[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx.out_valid = 1'b0;
        tx.out_data  = 8'h00;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (w_dirty[r_ptr]) begin
                    w_capture    = 1'b1;
                    w_state_next = S_STATUS;
                end
            end
            S_STATUS: begin
                tx.out_valid = 1'b1;
                tx.out_data  = c_status;
                if (tx.out_ready) begin
                    w_state_next = S_CTRL;
                end
            end
            S_CTRL: begin
                tx.out_valid = 1'b1;
                tx.out_data  = c_cc_base + {4'h0, r_idx};
                if (tx.out_ready) begin
                    w_state_next = S_VALUE;
                end
            end
            S_VALUE: begin
                tx.out_valid = 1'b1;
                tx.out_data  = {1'b0, r_val};
                if (tx.out_ready) begin
                    w_commit     = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            default: begin
                w_state_next = S_SCAN;
            end
        endcase
    end

    // Shadow takes the raw value captured at SCAN, not the live one, so a field
    // that moved mid-message stays dirty and is resent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_fields; i++) begin
                r_shadow[i] <= '0;
            end
            r_force        <= '1;
            r_ptr          <= 4'd0;
            r_idx          <= 4'd0;
            r_val          <= 7'd0;
            r_raw          <= '0;
            r_dump_pending <= 1'b1;
            r_live         <= 1'b0;
        end else begin
            r_live <= 1'b1;

            if (w_capture) begin
                r_idx <= r_ptr;
                r_val <= w_cc[r_ptr];
                r_raw <= w_raw[r_ptr];
            end else if (r_state == S_SCAN) begin
                r_ptr <= f_next(r_ptr);
            end

            if (w_commit) begin
                r_shadow[r_idx] <= r_raw;
                r_ptr           <= f_next(r_idx);
            end

            if (dump_req) begin
                r_force <= '1;
            end else if (w_capture) begin
                r_force[r_ptr] <= 1'b0;
            end

            if (dump_req) begin
                r_dump_pending <= 1'b1;
            end else if (dump_done) begin
                r_dump_pending <= 1'b0;
            end
        end
    end

    assign dump_done = r_dump_pending & (r_force == '0) & (r_state == S_SCAN) & ~(|w_dirty);

    // Held low while in reset and for the first cycle out of it.
    assign busy = r_live & ((r_state != S_SCAN) | (|w_dirty));

endmodule

`default_nettype wire

// File: doc/param_cc_transmitter.md
Name: param_cc_transmitter

Overview:
- Reverse direction of the MIDI CC parameter path: serialises the live PARAMETER::parameter_t into MIDI Control Change messages (status, controller, value bytes) for the UART transmitter, so an external controller or editor mirrors the synth state.
- Keeps a shadow copy of the last value sent per field. Sends only changed fields, or every field on a dump request or after reset.
- Sits between the parameter register bank and the MIDI UART TX byte interface.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) placed in the status-byte low nibble.
- CC_BASE, 20, controller number of field 0; field i uses CC_BASE+i (CC_BASE+12 must be ≤ 119).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- params  input  $bits(parameter_t)  live parameter struct
- dump_req  input  1  single-cycle pulse: resend all 13 fields
- out_data  output  8  MIDI byte to UART TX
- out_valid  output  1  out_data valid
- out_ready  input  1  UART TX accepts byte this cycle
- busy  output  1  message in flight or any field dirty
- dump_done  output  1  one-cycle pulse when a dump request has been fully sent

Behaviour:
- One clock; reset is asynchronous and active-low. All state clears immediately on rst_n low.
- Field index order follows struct declaration: 0 volume, 1 unison_detune, 2 attack_time, 3 decay_time, 4 sustain_level, 5 release_time, 6 tempo, 7 wave, 8 duty_cycle, 9 dispatcher_mode, 10 arp_mode, 11 arp_rate, 12 arp_rhythm.
- CC value conversion:
  - Fields narrower than 7 bits are zero-extended.
  - Fields of 7 bits are passed through.
  - Fields wider than 7 bits saturate at 127.
  - Shadow compare uses the full field width.
- dirty[i] = (params field i != shadow[i]) | force[i]. force[12:0] is set to all ones by dump_req and by reset release.
- Reset values:
  - out_valid=0, out_data=8'h00, busy=0, dump_done=0.
  - shadow=0, force=all ones, ptr=0, dump_pending=1, state=SCAN.
  - A full dump therefore starts automatically after reset.
- FSM states:
  - SCAN: if dirty[ptr], capture idx=ptr and val=converted field, clear force[ptr], go STATUS. Otherwise ptr advances (12 wraps to 0), one field per cycle.
  - STATUS: out_valid=1, out_data={4'hB, CHANNEL[3:0]}. On out_ready go CTRL.
  - CTRL: out_data=CC_BASE+idx. On out_ready go VALUE.
  - VALUE: out_data={1'b0, val}. On out_ready: shadow[idx] ← captured raw field, ptr ← idx+1 (wrap), go SCAN.
- Handshake: a byte transfers when out_valid & out_ready. out_data is stable while out_valid is high and ready is low. No running status; every message is exactly 3 bytes. There is no idle gap requirement; SCAN adds ≥1 cycle between messages.
- Value snapshot: val and the raw field are captured at SCAN. A field change during its own transmission is not mixed into the message. Because shadow holds the captured value, the new value is still dirty and is resent on a later scan.
- dump_req while busy: force is re-set to all ones. The in-flight message completes, then all 13 fields are sent, in round-robin order from the current ptr.
- dump_done: pulses for one cycle when dump_pending=1 and force==0 and state returns to SCAN with no dirty field. dump_pending is then cleared; dump_req sets it.
- busy = (state != SCAN) | (|dirty).
- Reset mid-message: out_valid drops asynchronously. The partial message is abandoned, and the full dump restarts after release.
- Worst-case fresh-state latency: a change is observed within 13 cycles plus any in-flight message.

Test Plan:
- Reset release with CHANNEL=2, CC_BASE=20, volume=100, out_ready=1 -> first bytes B2 14 64, then 12 more messages CC 0x15..0x20 (39 bytes total), then dump_done pulse and busy=0.
- Idle, set attack_time=0x33 -> exactly one message B2 16 33; no other bytes follow.
- Hold out_ready=0 for 5 cycles during the CTRL byte -> out_valid stays 1, out_data stays 0x16, and no byte is duplicated or lost when ready returns.
- Change decay_time 10→20 during the STATUS byte of its own message -> message carries 0x0A, followed later by B2 17 14.
- dump_req asserted mid-message -> current message completes intact, then 13 messages are sent, then dump_done pulses.
- Deassert rst_n during the VALUE byte -> out_valid=0 immediately; after release a full 39-byte dump starting from field 0 is sent.
